sprite_table_controller: RTL and testbench
==========================================

// Module: sprite_table_controller
// PURPOSE
//  Video-side command receiver for the game processor. Accepts sprite and
//  background commands (SPRITE_POS, SPRITE_LEVEL, BG_POS, WAIT_VSYNC) over a
//  valid/ready interface and writes them into a shadow table.
//  On vsync, copies the shadow table into the active table that the sprite
//  renderer reads. Pulses vsync_done to release a processor blocked in WAIT_VSYNC.
// PARAMETERS
//  NUM_SPRITES  32  table entries; sprite_id width = $clog2(NUM_SPRITES) (5)
//  COORD_WIDTH  10  width of x/y coordinates
//  LEVEL_WIDTH  2   sprite level; level 0 = sprite disabled
// PORTS
//  clock           in   1   single system clock
//  reset           in   1   asynchronous, active-low reset
//  cmd_valid       in   1   command present
//  cmd_ready       out  1   command accepted when cmd_valid && cmd_ready
//  cmd_opcode      in   5   FUNCTION_* code
//  cmd_sprite_id   in   5   target entry
//  cmd_x, cmd_y    in   COORD_WIDTH each  position operands
//  cmd_level       in   LEVEL_WIDTH  level operand
//  vsync           in   1   one-cycle frame-start pulse from video timing
//  rd_index        in   5   renderer read address
//  rd_x, rd_y      out  COORD_WIDTH  active entry x/y (registered, 1-cycle latency)
//  rd_level        out  LEVEL_WIDTH  active entry level
//  background_x/y  out  COORD_WIDTH  active background offset
//  vsync_done      out  1   one-cycle pulse at end of commit
//  frame_overrun   out  1   one-cycle pulse: vsync arrived during COPY
// BEHAVIOUR
//  Reset: all shadow/active entries are x=0, y=0, level=0.
//   background_x/y = 0, rd_* = 0, cmd_ready = 0, vsync_done = 0,
//   frame_overrun = 0, state = IDLE.
//  FSM: IDLE (cmd_ready=1), WAIT (cmd_ready=0), COPY (cmd_ready=0).
//   IDLE: vsync -> COPY. Accepted WAIT_VSYNC -> WAIT.
//   WAIT: vsync -> COPY.
//   COPY: copy_idx runs 0..NUM_SPRITES-1, one entry per cycle;
//    shadow[i] -> active[i]; after the last entry -> IDLE.
//   On the first IDLE cycle after COPY: vsync_done=1 for exactly one cycle.
//   This pulse occurs on every commit, whether or not the commit was entered from WAIT.
//  Commit timing: vsync sampled at edge T.
//   background_x/y load from shadow at edge T+1.
//   Entry i is written at edge T+1+i.
//   IDLE, with vsync_done high, holds from edge T+1+NUM_SPRITES.
//  Commands (accepted in IDLE only), each written to shadow on the accepting edge:
//   SPRITE_POS 5'b00010:   shadow[id].x/y <= cmd_x/cmd_y.
//   SPRITE_LEVEL 5'b00001: shadow[id].level <= cmd_level.
//   BG_POS 5'b00111:       shadow background <= cmd_x/cmd_y.
//   WAIT_VSYNC 5'b00110:   enter WAIT.
//   Any other opcode: accepted, no effect.
//  Simultaneous cmd and vsync in IDLE: the command is accepted and is included
//   in the commit starting next cycle. WAIT_VSYNC in that cycle goes straight
//   to COPY (vsync wins).
//  vsync during COPY: ignored (copy not restarted); frame_overrun pulses 1 cycle.
//  Read port: rd_* <= active[rd_index] each cycle.
//   Reading the entry being written in the same cycle returns the old value.
//  Widths: coordinates stored unsigned, no clamping or wrap. rd_index >= NUM_SPRITES returns 0.
//  Reset mid-COPY: tables return to reset values immediately; no vsync_done pulse.
// STRUCTURE
//  Shared package:
//   - FUNCTION_* opcode constants (shared with the processor)
//   - BG_POS code
//   - entry width = 2*COORD_WIDTH + LEVEL_WIDTH
//   - FSM state encoding
//  Sub-module sprite_table_ram: 1 write / 1 read port, registered read.
//   Instantiated twice: shadow (cmd write, copy read) and active (copy write, renderer read).
// TESTING
//  1 Release reset; read indices 0..31 -> all zero; cmd_ready=1 on first post-reset cycle.
//  2 POS id3 (100,50), LEVEL id3=2 -> rd idx3 still 0.
//    vsync at T -> idx3 = (100,50,2) readable after T+4; vsync_done at T+33.
//  3 WAIT_VSYNC accepted; vsync 10 cycles later -> cmd_ready low for 10+33 cycles;
//    single vsync_done pulse; cmd_ready returns high.
//  4 SPRITE_POS id31 (639,479) on same cycle as vsync in IDLE -> committed this frame;
//    BG_POS (5,7) -> background_x/y = 5/7 one cycle after vsync.
//  5 Second vsync at T+10 during COPY -> frame_overrun pulses once;
//    vsync_done still at T+33.
//  6 Assert reset at T+15 mid-COPY -> all rd_* and background = 0; no vsync_done;
//    cmd_ready=1 after release.

Source files
------------

// File: rtl/sprite_table_controller_pkg.sv
// Shared constants, opcodes, FSM encoding and entry layout for the sprite table controller.
package sprite_table_controller_pkg;

  localparam int unsigned NUM_SPRITES    = 32;
  localparam int unsigned COORD_WIDTH    = 10;
  localparam int unsigned LEVEL_WIDTH    = 2;
  localparam int unsigned OPCODE_WIDTH   = 5;
  localparam int unsigned ID_WIDTH       = $clog2(NUM_SPRITES);
  localparam int unsigned ENTRY_WIDTH    = 2 * COORD_WIDTH + LEVEL_WIDTH;
  // Copy counter needs one extra value for the trailing cycle after the last entry
  localparam int unsigned COPY_CNT_WIDTH = $clog2(NUM_SPRITES + 1);

  // Command opcodes shared with the game processor
  localparam logic [OPCODE_WIDTH-1:0] FUNCTION_SPRITE_LEVEL = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] FUNCTION_SPRITE_POS   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] FUNCTION_WAIT_VSYNC   = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] FUNCTION_BG_POS       = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_COPY = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [LEVEL_WIDTH-1:0] level;
  } sprite_entry_t;

endpackage

// File: rtl/sprite_table_ram.sv
// Flop-based table: one masked write port, one registered read port.
// WRITE_FIRST selects whether a same-cycle write to the read address is seen.
module sprite_table_ram #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WIDTH       = 22,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter bit          WRITE_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             waddr_ok;
  logic             raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < (AW + 1)'(DEPTH));
  assign raddr_ok = ({1'b0, raddr} < (AW + 1)'(DEPTH));

  // Masked write merge and read-data selection
  always_comb begin
    mem_d   = mem_q;
    rdata_d = '0;
    if (we && waddr_ok) begin
      mem_d[waddr] = (mem_q[waddr] & ~wmask) | (wdata & wmask);
    end
    if (raddr_ok) begin
      rdata_d = WRITE_FIRST ? mem_d[raddr] : mem_q[raddr];
    end
  end

  // Table storage and read register, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_table_controller.sv
// Sprite/background command receiver with shadow table and vsync-timed commit
// into the active table read by the renderer.
module sprite_table_controller
  import sprite_table_controller_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [ID_WIDTH-1:0]     cmd_sprite_id,
  input  logic [COORD_WIDTH-1:0]  cmd_x,
  input  logic [COORD_WIDTH-1:0]  cmd_y,
  input  logic [LEVEL_WIDTH-1:0]  cmd_level,
  input  logic                    vsync,
  input  logic [ID_WIDTH-1:0]     rd_index,
  output logic [COORD_WIDTH-1:0]  rd_x,
  output logic [COORD_WIDTH-1:0]  rd_y,
  output logic [LEVEL_WIDTH-1:0]  rd_level,
  output logic [COORD_WIDTH-1:0]  background_x,
  output logic [COORD_WIDTH-1:0]  background_y,
  output logic                    vsync_done,
  output logic                    frame_overrun
);

  localparam logic [COPY_CNT_WIDTH-1:0] COPY_LAST = COPY_CNT_WIDTH'(NUM_SPRITES);

  state_t                     state_q, state_d;
  logic [COPY_CNT_WIDTH-1:0]  copy_idx_q, copy_idx_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       vsync_done_q, vsync_done_d;
  logic                       frame_overrun_q, frame_overrun_d;
  logic [COORD_WIDTH-1:0]     shadow_bg_x_q, shadow_bg_x_d;
  logic [COORD_WIDTH-1:0]     shadow_bg_y_q, shadow_bg_y_d;
  logic [COORD_WIDTH-1:0]     bg_x_q, bg_x_d;
  logic [COORD_WIDTH-1:0]     bg_y_q, bg_y_d;

  logic                       cmd_accept;
  logic                       shadow_we;
  sprite_entry_t              shadow_wdata;
  sprite_entry_t              shadow_wmask;
  logic [ID_WIDTH-1:0]        shadow_raddr;
  sprite_entry_t              shadow_rdata;
  logic                       active_we;
  logic [ID_WIDTH-1:0]        active_waddr;
  sprite_entry_t              active_rdata;

  assign cmd_accept = cmd_valid && cmd_ready_q;

  // Commit FSM: IDLE accepts commands, WAIT blocks until vsync, COPY streams shadow to active
  always_comb begin
    state_d         = state_q;
    copy_idx_d      = copy_idx_q;
    vsync_done_d    = 1'b0;
    frame_overrun_d = 1'b0;
    bg_x_d          = bg_x_q;
    bg_y_d          = bg_y_q;
    case (state_q)
      ST_IDLE: begin
        if (vsync) begin
          state_d    = ST_COPY;
          copy_idx_d = '0;
        end else if (cmd_accept && (cmd_opcode == FUNCTION_WAIT_VSYNC)) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (vsync) begin
          state_d    = ST_COPY;
          copy_idx_d = '0;
        end
      end
      ST_COPY: begin
        frame_overrun_d = vsync;
        if (copy_idx_q == '0) begin
          bg_x_d = shadow_bg_x_q;
          bg_y_d = shadow_bg_y_q;
        end
        if (copy_idx_q == COPY_LAST) begin
          state_d      = ST_IDLE;
          vsync_done_d = 1'b1;
        end else begin
          copy_idx_d = copy_idx_q + COPY_CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Decode accepted commands into shadow-table and shadow-background writes
  always_comb begin
    shadow_we          = 1'b0;
    shadow_wdata.x     = cmd_x;
    shadow_wdata.y     = cmd_y;
    shadow_wdata.level = cmd_level;
    shadow_wmask       = '0;
    shadow_bg_x_d      = shadow_bg_x_q;
    shadow_bg_y_d      = shadow_bg_y_q;
    if (cmd_accept) begin
      case (cmd_opcode)
        FUNCTION_SPRITE_POS: begin
          shadow_we      = 1'b1;
          shadow_wmask.x = '1;
          shadow_wmask.y = '1;
        end
        FUNCTION_SPRITE_LEVEL: begin
          shadow_we          = 1'b1;
          shadow_wmask.level = '1;
        end
        FUNCTION_BG_POS: begin
          shadow_bg_x_d = cmd_x;
          shadow_bg_y_d = cmd_y;
        end
        default: begin
        end
      endcase
    end
  end

  // Shadow read runs one entry ahead of the active write; entry 0 is prefetched while not copying
  assign shadow_raddr = (state_q == ST_COPY) ? (copy_idx_q[ID_WIDTH-1:0] + ID_WIDTH'(1)) : '0;
  assign active_we    = (state_q == ST_COPY) && (copy_idx_q < COPY_LAST);
  assign active_waddr = copy_idx_q[ID_WIDTH-1:0];

  // Control and background registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      copy_idx_q      <= '0;
      cmd_ready_q     <= 1'b0;
      vsync_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
      shadow_bg_x_q   <= '0;
      shadow_bg_y_q   <= '0;
      bg_x_q          <= '0;
      bg_y_q          <= '0;
    end else begin
      state_q         <= state_d;
      copy_idx_q      <= copy_idx_d;
      cmd_ready_q     <= cmd_ready_d;
      vsync_done_q    <= vsync_done_d;
      frame_overrun_q <= frame_overrun_d;
      shadow_bg_x_q   <= shadow_bg_x_d;
      shadow_bg_y_q   <= shadow_bg_y_d;
      bg_x_q          <= bg_x_d;
      bg_y_q          <= bg_y_d;
    end
  end

  // Write-first so a command accepted together with vsync lands in this commit
  sprite_table_ram #(
    .DEPTH       (NUM_SPRITES),
    .WIDTH       (ENTRY_WIDTH),
    .AW          (ID_WIDTH),
    .WRITE_FIRST (1'b1)
  ) u_shadow (
    .clock (clock),
    .reset (reset),
    .we    (shadow_we),
    .waddr (cmd_sprite_id),
    .wdata (shadow_wdata),
    .wmask (shadow_wmask),
    .raddr (shadow_raddr),
    .rdata (shadow_rdata)
  );

  // Read-old so the renderer sees the previous value of an entry being written
  sprite_table_ram #(
    .DEPTH       (NUM_SPRITES),
    .WIDTH       (ENTRY_WIDTH),
    .AW          (ID_WIDTH),
    .WRITE_FIRST (1'b0)
  ) u_active (
    .clock (clock),
    .reset (reset),
    .we    (active_we),
    .waddr (active_waddr),
    .wdata (shadow_rdata),
    .wmask ('1),
    .raddr (rd_index),
    .rdata (active_rdata)
  );

  assign cmd_ready     = cmd_ready_q;
  assign rd_x          = active_rdata.x;
  assign rd_y          = active_rdata.y;
  assign rd_level      = active_rdata.level;
  assign background_x  = bg_x_q;
  assign background_y  = bg_y_q;
  assign vsync_done    = vsync_done_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_sprite_table_controller.sv
// Scoreboard bench for sprite_table_controller: a time-based commit model
// pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_sprite_table_controller;

  localparam int NS = 32;
  localparam logic [4:0] OP_LEVEL = 5'b00001;
  localparam logic [4:0] OP_POS   = 5'b00010;
  localparam logic [4:0] OP_WAIT  = 5'b00110;
  localparam logic [4:0] OP_BG    = 5'b00111;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_opcode;
  logic [4:0] cmd_sprite_id;
  logic [9:0] cmd_x, cmd_y;
  logic [1:0] cmd_level;
  logic       vsync;
  logic [4:0] rd_index;
  logic [9:0] rd_x, rd_y;
  logic [1:0] rd_level;
  logic [9:0] background_x, background_y;
  logic       vsync_done, frame_overrun;

  sprite_table_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_sprite_id (cmd_sprite_id),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .cmd_level     (cmd_level),
    .vsync         (vsync),
    .rd_index      (rd_index),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_level      (rd_level),
    .background_x  (background_x),
    .background_y  (background_y),
    .vsync_done    (vsync_done),
    .frame_overrun (frame_overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ready;
    logic [9:0] rx;
    logic [9:0] ry;
    logic [1:0] rl;
    logic [9:0] bx;
    logic [9:0] by;
    logic       done;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------- reference model ----------------
  logic [9:0] sh_x [NS];
  logic [9:0] sh_y [NS];
  logic [1:0] sh_l [NS];
  logic [9:0] ac_x [NS];
  logic [9:0] ac_y [NS];
  logic [1:0] ac_l [NS];
  logic [9:0] sn_x [NS];
  logic [9:0] sn_y [NS];
  logic [1:0] sn_l [NS];
  logic [9:0] sh_bx, sh_by, sn_bx, sn_by, ac_bx, ac_by;
  logic       m_ready, m_busy, m_wait;
  int         cyc, t0;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = '0; sh_y[i] = '0; sh_l[i] = '0;
      ac_x[i] = '0; ac_y[i] = '0; ac_l[i] = '0;
    end
    sh_bx = '0; sh_by = '0; ac_bx = '0; ac_by = '0;
    m_ready = 1'b0; m_busy = 1'b0; m_wait = 1'b0;
    cyc = 0; t0 = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    logic was_busy;
    int   k;
    cyc = cyc + 1;
    e = '0;
    if (int'(rd_index) < NS) begin
      e.rx = ac_x[rd_index]; e.ry = ac_y[rd_index]; e.rl = ac_l[rd_index];
    end
    if (cmd_valid && m_ready) begin
      if (cmd_opcode == OP_POS) begin
        sh_x[cmd_sprite_id] = cmd_x; sh_y[cmd_sprite_id] = cmd_y;
      end else if (cmd_opcode == OP_LEVEL) begin
        sh_l[cmd_sprite_id] = cmd_level;
      end else if (cmd_opcode == OP_BG) begin
        sh_bx = cmd_x; sh_by = cmd_y;
      end else if (cmd_opcode == OP_WAIT) begin
        m_wait = 1'b1;
      end
    end
    was_busy = m_busy;
    if (m_busy) begin
      k = cyc - t0;
      if (k >= 1 && k <= NS) begin
        ac_x[k-1] = sn_x[k-1]; ac_y[k-1] = sn_y[k-1]; ac_l[k-1] = sn_l[k-1];
      end
      if (k == 1) begin
        ac_bx = sn_bx; ac_by = sn_by;
      end
      if (vsync) e.ovr = 1'b1;
      if (k == NS + 1) begin
        m_busy = 1'b0;
        e.done = 1'b1;
      end
    end
    if (!was_busy && vsync) begin
      m_busy = 1'b1; m_wait = 1'b0; t0 = cyc;
      sn_x = sh_x; sn_y = sh_y; sn_l = sh_l; sn_bx = sh_bx; sn_by = sh_by;
    end
    m_ready = !m_busy && !m_wait;
    e.ready = m_ready;
    e.bx = ac_bx; e.by = ac_by;
    exp_q.push_back(e);
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_edge();
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  exp_t me;
  always @(negedge clock) begin
    if (!reset) begin
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_rd_x", 32'(rd_x), 32'd0);
      chk("reset_rd_y", 32'(rd_y), 32'd0);
      chk("reset_rd_level", 32'(rd_level), 32'd0);
      chk("reset_bg_x", 32'(background_x), 32'd0);
      chk("reset_bg_y", 32'(background_y), 32'd0);
      chk("reset_vsync_done", 32'(vsync_done), 32'd0);
      chk("reset_overrun", 32'(frame_overrun), 32'd0);
    end else if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk("cmd_ready", 32'(cmd_ready), 32'(me.ready));
      chk("rd_x", 32'(rd_x), 32'(me.rx));
      chk("rd_y", 32'(rd_y), 32'(me.ry));
      chk("rd_level", 32'(rd_level), 32'(me.rl));
      chk("background_x", 32'(background_x), 32'(me.bx));
      chk("background_y", 32'(background_y), 32'(me.by));
      chk("vsync_done", 32'(vsync_done), 32'(me.done));
      chk("frame_overrun", 32'(frame_overrun), 32'(me.ovr));
    end
  end

  // ---------------- stimulus ----------------
  int         rd_mode = 0;
  logic [4:0] rd_fixed = '0;
  logic [4:0] rd_sweep = '0;

  task automatic clear_cmd();
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_sprite_id = '0;
    cmd_x = '0; cmd_y = '0; cmd_level = '0; vsync = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
    rd_sweep = rd_sweep + 5'd1;
    case (rd_mode)
      0:       rd_index = rd_sweep;
      1:       rd_index = 5'($urandom);
      default: rd_index = rd_fixed;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] id, input logic [9:0] x,
                       input logic [9:0] y, input logic [1:0] lv, input logic vs);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_sprite_id = id;
    cmd_x = x; cmd_y = y; cmd_level = lv; vsync = vs;
    tick();
    clear_cmd();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic mid_reset(input int n);
    clear_cmd();
    @(posedge clock);
    #2 reset = 1'b0;
    idle(n);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    rd_index = '0;
    clear_cmd();
    #1 reset = 1'b0;
    idle(3);
    #2 reset = 1'b1;

    // all entries zero after reset, ready on first cycle
    idle(34);

    // position+level on id3, committed by vsync
    rd_mode = 2; rd_fixed = 5'd3;
    issue(OP_POS, 5'd3, 10'd100, 10'd50, 2'd0, 1'b0);
    issue(OP_LEVEL, 5'd3, 10'd0, 10'd0, 2'd2, 1'b0);
    idle(3);
    pulse_vsync();
    idle(40);

    // WAIT_VSYNC holds ready low until the commit finishes
    rd_mode = 0;
    issue(OP_WAIT, 5'd0, 10'd0, 10'd0, 2'd0, 1'b0);
    issue(OP_POS, 5'd7, 10'd9, 10'd9, 2'd0, 1'b0);
    idle(8);
    pulse_vsync();
    idle(40);

    // command together with vsync is included in the commit; background too
    issue(OP_BG, 5'd0, 10'd5, 10'd7, 2'd0, 1'b0);
    rd_mode = 2; rd_fixed = 5'd31;
    issue(OP_POS, 5'd31, 10'd639, 10'd479, 2'd0, 1'b1);
    idle(40);

    // WAIT_VSYNC with vsync in the same cycle goes straight to the commit
    issue(OP_WAIT, 5'd0, 10'd0, 10'd0, 2'd0, 1'b1);
    idle(38);

    // second vsync during the copy is flagged and ignored
    rd_mode = 0;
    pulse_vsync();
    idle(9);
    pulse_vsync();
    idle(30);

    // reset in the middle of a copy
    pulse_vsync();
    idle(14);
    mid_reset(3);
    idle(34);

    // randomized traffic
    rd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i == 1500) mid_reset(2);
      r = int'($urandom_range(0, 15));
      cmd_valid     = ($urandom_range(0, 2) != 0);
      cmd_sprite_id = 5'($urandom);
      cmd_x         = 10'($urandom);
      cmd_y         = 10'($urandom);
      cmd_level     = 2'($urandom);
      if (r < 6)       cmd_opcode = OP_POS;
      else if (r < 10) cmd_opcode = OP_LEVEL;
      else if (r < 12) cmd_opcode = OP_BG;
      else if (r == 12) cmd_opcode = OP_WAIT;
      else             cmd_opcode = 5'($urandom);
      vsync = ($urandom_range(0, 49) == 0);
      tick();
    end
    clear_cmd();
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
